// File: rtl/cell_sched_pkg.sv
// Shared types for the cell scheduler: RGB cell, opcode, FSM states and the
// latched request bundle handed to the CellProcessor.
package cell_sched_pkg;

  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef logic [3:0] opcode_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;

  typedef struct packed {
    rgb_t    cell_a;
    rgb_t    cell_b;
    opcode_t opcode;
  } cell_req_t;

endpackage

// File: rtl/cell_sched_if.sv
// Requester, response and CellProcessor-side signals of the cell scheduler.
// slave = scheduler view, master = requester/processor environment view.
interface cell_sched_if #(
  parameter int CNT_W = 16
) ();
  import cell_sched_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [23:0]        cellA0, cellB0, cellA1, cellB1;
  logic [3:0]         opcode0, opcode1;
  logic [NUM_REQ-1:0] grant;
  logic [23:0]        rsp_data;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [NUM_REQ-1:0] rsp_ready;
  logic [23:0]        proc_cellA, proc_cellB;
  logic [3:0]         proc_opcode;
  logic               proc_start;
  logic [23:0]        processedCell;
  logic               busy;
  logic [CNT_W-1:0]   op_count;

  modport slave (
    input  req, cellA0, cellB0, cellA1, cellB1, opcode0, opcode1,
           rsp_ready, processedCell,
    output grant, rsp_data, rsp_valid, proc_cellA, proc_cellB,
           proc_opcode, proc_start, busy, op_count
  );

  modport master (
    output req, cellA0, cellB0, cellA1, cellB1, opcode0, opcode1,
           rsp_ready, processedCell,
    input  grant, rsp_data, rsp_valid, proc_cellA, proc_cellB,
           proc_opcode, proc_start, busy, op_count
  );

endinterface

// File: rtl/rr_arbiter.sv
// Two-way round-robin arbiter. The priority pointer is held here and is
// reloaded from 'pointer' whenever 'advance' pulses.
module rr_arbiter
  import cell_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               pointer,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = advance ? pointer : ptr_q;
    gnt   = '0;
    if (req[ptr_q])       gnt[ptr_q]  = 1'b1;
    else if (req[~ptr_q]) gnt[~ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cell_scheduler.sv
// Time-shares one CellProcessor between two requesters: round-robin grant,
// operand latch, fixed-latency wait, then valid/ready return of the result.
module cell_scheduler
  import cell_sched_pkg::*;
#(
  parameter int PROC_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic       SYSCLK,
  input  logic       RST,
  cell_sched_if.slave bus
);

  cell_req_t [NUM_REQ-1:0] req_in;
  assign req_in[0] = {bus.cellA0, bus.cellB0, bus.opcode0};
  assign req_in[1] = {bus.cellA1, bus.cellB1, bus.opcode1};

  sched_state_t       state_q, state_d;
  logic               win_q, win_d;
  logic [3:0]         cnt_q, cnt_d;
  cell_req_t          proc_q, proc_d;
  logic               proc_start_q, proc_start_d;
  logic [23:0]        rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic               advance;
  logic [NUM_REQ-1:0] gnt;

  // Pointer always moves to the loser of the transaction just completed.
  rr_arbiter u_arb (
    .clk     (SYSCLK),
    .rst_n   (RST),
    .req     (bus.req),
    .pointer (~win_q),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    proc_d       = proc_q;
    proc_start_d = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_valid_d  = rsp_valid_q;
    op_count_d   = op_count_q;
    advance      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          win_d        = gnt[1];
          proc_d       = req_in[gnt[1]];
          proc_start_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 4'(PROC_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d         = bus.processedCell;
          rsp_valid_d[win_q] = 1'b1;
          state_d            = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready[win_q]) begin
          rsp_valid_d = '0;
          op_count_d  = op_count_q + 1'b1;
          advance     = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      win_q        <= 1'b0;
      cnt_q        <= '0;
      proc_q       <= '0;
      proc_start_q <= 1'b0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      proc_q       <= proc_d;
      proc_start_q <= proc_start_d;
      rsp_data_q   <= rsp_data_d;
      rsp_valid_q  <= rsp_valid_d;
      op_count_q   <= op_count_d;
    end
  end

  // Grant is Mealy on req; gated by RST so every output reads 0 in reset.
  assign bus.grant       = (state_q == IDLE && RST) ? gnt : '0;
  assign bus.proc_cellA  = proc_q.cell_a;
  assign bus.proc_cellB  = proc_q.cell_b;
  assign bus.proc_opcode = proc_q.opcode;
  assign bus.proc_start  = proc_start_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.op_count    = op_count_q;

endmodule

// File: tb/tb_cell_scheduler.sv
// Random-stimulus scoreboard bench for cell_scheduler, run on two builds:
// (latency 1, 16-bit counter) and (latency 4, 2-bit wrapping counter).
module tb_cell_scheduler;
  import cell_sched_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int          port;
    logic [23:0] a, b;
    logic [3:0]  op;
    logic [23:0] data;
    int          gcyc;
    int          vcyc;
  } exp_t;

  // Behaviour of the external CellProcessor, per 8-bit channel.
  function automatic logic [23:0] proc_model(input logic [23:0] a, input logic [23:0] b,
                                             input logic [3:0] op);
    logic [23:0] r;
    int x, y, z;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      x = int'(a[i*8 +: 8]);
      y = int'(b[i*8 +: 8]);
      case (op[1:0])
        2'd0:    z = (x + y > 255) ? 255 : x + y;
        2'd1:    z = (x > y) ? x - y : 0;
        2'd2:    z = (x + y) / 2;
        default: z = x ^ y ^ int'(op);
      endcase
      r[i*8 +: 8] = 8'(z);
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act_v, exp_v);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int L  = (g == 0) ? 1 : 4;
    localparam int CW = (g == 0) ? 16 : 2;

    logic rst_n;
    cell_sched_if #(.CNT_W(CW)) bus ();
    cell_scheduler #(.PROC_LATENCY(L), .CNT_W(CW)) dut (
      .SYSCLK (clk),
      .RST    (rst_n),
      .bus    (bus)
    );

    exp_t gnt_q[$];
    exp_t rsp_q[$];

    // Processor stub: correct result only on the L-th cycle after proc_start.
    int k;
    bit act;
    always @(negedge clk) begin
      if (!rst_n) act = 1'b0;
      else if (bus.proc_start) begin act = 1'b1; k = L; end
      else if (act) k--;
      if (act && k == 0) begin
        bus.processedCell = proc_model(bus.proc_cellA, bus.proc_cellB, bus.proc_opcode);
        act = 1'b0;
      end else begin
        bus.processedCell = 24'($urandom);
      end
    end

    // Driver + transaction-level reference model.
    initial begin
      bit [1:0]    pend, rdy;
      bit          busy_m, did_rst, force11, raise, drop;
      int          ptr_m, idle_from, win_m, gcyc_m, vcyc_m;
      logic [23:0] a [2];
      logic [23:0] b [2];
      logic [3:0]  op [2];
      exp_t        e;
      pend = '0; busy_m = 0; did_rst = 0; force11 = 0;
      ptr_m = 0; idle_from = 0; win_m = 0; gcyc_m = 0; vcyc_m = 0;
      for (int p = 0; p < 2; p++) begin a[p] = '0; b[p] = '0; op[p] = '0; end
      rst_n = 1'b0;
      bus.req = '0; bus.rsp_ready = '0;
      bus.cellA0 = '0; bus.cellB0 = '0; bus.cellA1 = '0; bus.cellB1 = '0;
      bus.opcode0 = '0; bus.opcode1 = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 600; n++) begin
        @(negedge clk);
        // One asynchronous reset pulse landing in WAIT.
        if (n >= 400 && !did_rst && busy_m && cyc == gcyc_m + 2) begin
          rst_n = 1'b0; did_rst = 1; busy_m = 0; ptr_m = 0; pend = '0;
          bus.req = '0; force11 = 1;
          continue;
        end
        rst_n = 1'b1;
        for (int p = 0; p < 2; p++) begin
          if (n < 12)      begin raise = (p == 0 && n == 0); drop = 0; end
          else if (n < 60) begin raise = 1; drop = 0; end
          else begin
            raise = ($urandom_range(2) == 0);
            drop  = ($urandom_range(19) == 0);
          end
          if (force11) raise = 1;
          if (pend[p] && drop) pend[p] = 1'b0;
          else if (!pend[p] && raise) begin
            pend[p] = 1'b1;
            a[p]  = 24'($urandom);
            b[p]  = 24'($urandom);
            op[p] = 4'($urandom);
          end
        end
        if (n == 0) begin a[0] = 24'h102030; b[0] = 24'h010203; op[0] = 4'h1; end
        force11 = 0;
        if (n < 60) rdy = 2'b11;
        else if (n >= 200 && n < 260)
          rdy = {($urandom_range(7) == 0), ($urandom_range(7) == 0)};
        else
          rdy = {($urandom_range(2) == 0), ($urandom_range(2) == 0)};
        bus.req = pend; bus.rsp_ready = rdy;
        bus.cellA0 = a[0]; bus.cellB0 = b[0]; bus.opcode0 = op[0];
        bus.cellA1 = a[1]; bus.cellB1 = b[1]; bus.opcode1 = op[1];
        if (busy_m && cyc >= vcyc_m && rdy[win_m]) begin
          busy_m = 0; ptr_m = 1 - win_m; idle_from = cyc + 1;
        end else if (!busy_m && cyc >= idle_from && pend != 2'b00) begin
          win_m  = pend[ptr_m] ? ptr_m : 1 - ptr_m;
          e.port = win_m; e.a = a[win_m]; e.b = b[win_m]; e.op = op[win_m];
          e.data = proc_model(a[win_m], b[win_m], op[win_m]);
          e.gcyc = cyc; e.vcyc = cyc + L + 2;
          gnt_q.push_back(e); rsp_q.push_back(e);
          busy_m = 1; gcyc_m = cyc; vcyc_m = e.vcyc;
          pend[win_m] = 1'b0;
        end
      end
    end

    // Monitor: compares DUT outputs with queued expectations each cycle.
    int exp_cnt = 0;
    always @(negedge clk) begin
      exp_t f;
      int   eg;
      bit   hs;
      #1;
      hs = 0;
      if (!rst_n) begin
        gnt_q.delete(); rsp_q.delete(); exp_cnt = 0;
        if (cyc >= 1)
          check($sformatf("cfg%0d reset_outs", g),
                64'({bus.grant, bus.rsp_valid, bus.proc_start, bus.busy, |bus.op_count,
                     |bus.rsp_data, |bus.proc_cellA, |bus.proc_cellB, |bus.proc_opcode}),
                64'(0));
      end else begin
        eg = 0;
        if (gnt_q.size() > 0 && gnt_q[0].gcyc == cyc) begin
          eg = 1 << gnt_q[0].port;
          gnt_q.pop_front();
        end
        if (eg != 0 || bus.grant != '0)
          check($sformatf("cfg%0d grant", g), 64'(bus.grant), 64'(eg));
        if (rsp_q.size() > 0) begin
          f = rsp_q[0];
          check($sformatf("cfg%0d busy", g), 64'(bus.busy), 64'(cyc > f.gcyc));
          check($sformatf("cfg%0d proc_start", g), 64'(bus.proc_start), 64'(cyc == f.gcyc + 1));
          if (cyc > f.gcyc)
            check($sformatf("cfg%0d proc_ops", g),
                  64'({bus.proc_cellA, bus.proc_cellB, bus.proc_opcode}),
                  64'({f.a, f.b, f.op}));
          if (cyc >= f.vcyc) begin
            check($sformatf("cfg%0d rsp", g), 64'({bus.rsp_valid, bus.rsp_data}),
                  64'({2'(1 << f.port), f.data}));
            if (bus.rsp_ready[f.port]) begin hs = 1; rsp_q.pop_front(); end
          end else begin
            check($sformatf("cfg%0d early_rsp", g), 64'(bus.rsp_valid), 64'(0));
          end
        end else begin
          check($sformatf("cfg%0d idle", g),
                64'({bus.busy, bus.proc_start, bus.rsp_valid}), 64'(0));
        end
        check($sformatf("cfg%0d op_count", g), 64'(bus.op_count), 64'(exp_cnt));
        if (hs) exp_cnt = (exp_cnt + 1) % (1 << CW);
      end
    end
  end

  initial begin
    repeat (640) @(posedge clk);
    @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
